dbi_decoder: RTL
================

DBI_DECODER -- requirements
Module: dbi_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bus data width (even, >=2).
REQ-002 SHALL have parameter ERR_W, default 8, error counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  WIDTH  raw bus word as transmitted by the DBI encoder.
REQ-006 SHALL have port in_inv  input  1  DBI flag; 1 = in_data was sent inverted.
REQ-007 SHALL have port in_valid  input  1  upstream word present.
REQ-008 SHALL have port in_ready  output  1  decoder can accept a word.
REQ-009 SHALL have port out_data  output  WIDTH  decoded word at buffer head.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port err_clr  input  1  synchronous clear of err_cnt.
REQ-013 SHALL have port err_cnt  output  ERR_W  saturating count of encoding-rule violations.
REQ-014 SHALL have port err_pulse  output  1  one-cycle pulse per violation.

Function
REQ-015 SHALL accept a word on a rising edge where in_valid && in_ready (push); SHALL pop on a rising edge where out_valid && out_ready.
REQ-016 SHALL decode each accepted word as in_inv ? ~in_data : in_data and store it in a 2-entry FIFO; stored order is output order.
REQ-017 SHALL drive in_ready = (count < 2), from registered count only; no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (count > 0) and out_data = FIFO head, both from registers.
REQ-019 SHALL give latency 1: word pushed into an empty FIFO at edge N is on out_data with out_valid high after edge N.
REQ-020 Simultaneous push and pop with count 1 SHALL keep count 1 and present the new word after the pop.
REQ-021 With count 2, in_ready SHALL be low that cycle even when out_ready is high; no push occurs.
REQ-022 SHALL keep prev_bus, the raw in_data of the last accepted word, updated only on push.
REQ-023 On push SHALL compute t = popcount(decoded ^ prev_bus) and expected_inv = (t > WIDTH/2).
REQ-024 On push with in_inv != expected_inv SHALL flag a violation; the word is still stored and output unchanged.
REQ-025 SHALL assert err_pulse for exactly the one cycle following the edge of each violating push.
REQ-026 SHALL increment err_cnt by 1 per violation, saturating at 2^ERR_W-1 (no wrap).
REQ-027 err_clr high at an edge SHALL set err_cnt to 0, or to 1 when a violation occurs at that same edge.
REQ-028 Non-pushing cycles (in_valid low or in_ready low) SHALL NOT alter prev_bus, err_cnt or err_pulse-generation state.
REQ-029 Pointers SHALL wrap modulo 2; the FIFO SHALL never overflow or underflow.

Reset
REQ-030 rst_n low SHALL immediately, without a clock, force: count=0, out_valid=0, in_ready=1, out_data=0, prev_bus=0, err_cnt=0, err_pulse=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words; the first push after release is checked against prev_bus=0.
REQ-032 Outputs SHALL remain at reset values until the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset, out_ready=1; push in_data=0xCC, in_inv=0 -> out_data=0xCC one cycle later, err_cnt=0 (t=4, not >4).
REQ-034 After reset push in_data=0x00, in_inv=1 -> out_data=0xFF, no error (t=8 > 4, inversion expected).
REQ-035 After reset push in_data=0xF0, in_inv=1 -> out_data=0x0F, err_pulse for one cycle, err_cnt=1 (t=4, inversion not expected).
REQ-036 out_ready=0, offer 0x11, 0x22, 0x33 (in_inv=0) back-to-back -> first two accepted, in_ready low, 0x33 held; out_ready=1 -> 0x11, 0x22, 0x33 in order, no loss or duplication.
REQ-037 ERR_W=8, 260 violating pushes -> err_cnt=255; err_clr together with a violation -> err_cnt=1.
REQ-038 Two words buffered and err_cnt=3, pulse rst_n low between edges -> out_valid=0, in_ready=1, err_cnt=0 immediately; next push 0x0F, in_inv=0 -> no error.

Source files
------------

// File: rtl/dbi_decoder.sv
// DBI decoder: restores inverted bus words, buffers them in a 2-entry FIFO and
// counts words whose DBI flag disagrees with the minimum-transition rule.
module dbi_decoder #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_pulse
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] prev_bus_q, prev_bus_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;

  logic             push, pop;
  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] diff;
  int               ones;
  logic             expected_inv;
  logic             viol;

  // Handshake outputs depend on registered occupancy only.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign err_cnt   = err_cnt_q;
  assign err_pulse = err_pulse_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // The encoder inverts when more than half the lines would toggle against
  // the previous raw bus word; recompute that decision and compare.
  always_comb begin
    decoded = in_inv ? ~in_data : in_data;
    diff    = decoded ^ prev_bus_q;
    ones    = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(diff[i]);
    end
    expected_inv = (ones > WIDTH / 2);
    viol         = push && (in_inv != expected_inv);
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can
    // leave a signal unassigned and infer a latch.
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    prev_bus_d  = prev_bus_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = viol;

    if (push) begin
      mem_d[wr_ptr_q] = decoded;
      wr_ptr_d        = ~wr_ptr_q;
      prev_bus_d      = in_data;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (err_clr) begin
      err_cnt_d = viol ? ERR_W'(1) : '0;
    end else if (viol && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // NOTE: the buffer storage is reset too, so out_data reads zero while in
  // reset instead of leaking a stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      prev_bus_q  <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every flop sample the pre-edge values.
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prev_bus_q  <= prev_bus_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule
